ex_stage_mdu: RTL

Parametrised next-generation execute stage for the 5-stage pipeline. It takes decoded operands from ID/EX, resolves two-level forwarding, runs a single-cycle ALU, and drives a registered EX/MEM output with individual fields instead of one packed vector. It adds an iterative multiply/divide unit with HI/LO registers and a stall handshake toward ID. It keeps the IRQ backup/recovery of the EX/MEM register.

---
 rtl/ex_stage_mdu.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_mdu
// Purpose  : Execute stage with two-level operand forwarding, single-cycle
//            ALU, iterative multiply/divide unit (HI/LO) with ID stall
//            handshake, and a registered EX/MEM output with IRQ backup.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_mdu #(
  parameter int WIDTH      = 32,
  parameter int REG_BITS   = 5,
  parameter int MDU_CYCLES = WIDTH
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [REG_BITS-1:0] rs_idx_i,
  input  logic [REG_BITS-1:0] rt_idx_i,
  input  logic [WIDTH-1:0]    rs_data_i,
  input  logic [WIDTH-1:0]    rt_data_i,
  input  logic [WIDTH-1:0]    imm_i,
  input  logic [4:0]          shamt_i,
  input  logic                alu_src_a_i,
  input  logic                alu_src_b_i,
  input  logic [3:0]          alu_op_i,
  input  logic [2:0]          md_op_i,
  input  logic [REG_BITS-1:0] wr_reg_i,
  input  logic                reg_write_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic                branch_i,
  input  logic [1:0]          mem_to_reg_i,
  input  logic [WIDTH-1:0]    pc_plus4_i,
  input  logic [REG_BITS-1:0] fwd1_rd_i,
  input  logic [REG_BITS-1:0] fwd2_rd_i,
  input  logic                fwd1_we_i,
  input  logic                fwd2_we_i,
  input  logic [WIDTH-1:0]    fwd1_data_i,
  input  logic [WIDTH-1:0]    fwd2_data_i,
  input  logic                mem_stall_i,
  input  logic                irq_backup_i,
  input  logic                irq_recovery_i,
  output logic                branch_taken_o,
  output logic                out_valid_o,
  output logic                out_reg_write_o,
  output logic                out_mem_read_o,
  output logic                out_mem_write_o,
  output logic [1:0]          out_mem_to_reg_o,
  output logic [REG_BITS-1:0] out_wr_reg_o,
  output logic [WIDTH-1:0]    out_result_o,
  output logic [WIDTH-1:0]    out_store_data_o,
  output logic [WIDTH-1:0]    out_pc_plus4_o,
  output logic                mdu_busy_o
);

  // Bits retired per RUN cycle; the last cycle may retire fewer.
  localparam int BPI    = (WIDTH + MDU_CYCLES - 1) / MDU_CYCLES;
  localparam int CNT_W  = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
  localparam int BITS_W = $clog2(2 * WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;
  localparam logic [2:0] MD_MT    = 3'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [1:0]          mem_to_reg;
    logic [REG_BITS-1:0] wr_reg;
    logic [WIDTH-1:0]    result;
    logic [WIDTH-1:0]    store_data;
    logic [WIDTH-1:0]    pc_plus4;
  } ex_out_t;

  state_t             state_q;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   work_hi_q, work_lo_q, opnd_q, dvd_raw_q;
  logic               is_div_q, neg_q, rneg_q, dz_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BITS_W-1:0]  bits_q;
  ex_out_t            out_q, bk_q, out_d;

  logic [WIDTH-1:0]   rs_fwd, rt_fwd, op_a, op_b, sh_amt, alu_res, result;
  logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, fix_hi, fix_lo;
  logic [WIDTH:0]     sum, rem;
  logic [2*WIDTH-1:0] prod_s;
  logic               ge, accept, md_start, md_sign, md_div, md_kill, taken;

  // Forwarding: newest producer (EX/MEM) wins over MEM/WB; register 0 never forwards.
  assign rs_fwd = (fwd1_we_i && fwd1_rd_i != '0 && fwd1_rd_i == rs_idx_i) ? fwd1_data_i :
                  (fwd2_we_i && fwd2_rd_i != '0 && fwd2_rd_i == rs_idx_i) ? fwd2_data_i :
                  rs_data_i;
  assign rt_fwd = (fwd1_we_i && fwd1_rd_i != '0 && fwd1_rd_i == rt_idx_i) ? fwd1_data_i :
                  (fwd2_we_i && fwd2_rd_i != '0 && fwd2_rd_i == rt_idx_i) ? fwd2_data_i :
                  rt_data_i;

  assign op_a   = alu_src_a_i ? {{(WIDTH-5){1'b0}}, shamt_i} : rs_fwd;
  assign op_b   = alu_src_b_i ? imm_i : rt_fwd;
  assign sh_amt = op_a % WIDTH_V;

  // Single-cycle ALU; shifts move B by A, everything wraps silently.
  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = ~(op_a | op_b);
      4'd6:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      4'd8:    alu_res = op_b << sh_amt;
      4'd9:    alu_res = op_b >> sh_amt;
      4'd10:   alu_res = $signed(op_b) >>> sh_amt;
      4'd11:   alu_res = {{(WIDTH-1){1'b0}}, (op_a == op_b)};
      4'd12:   alu_res = {{(WIDTH-1){1'b0}}, (op_a != op_b)};
      4'd13:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign md_start = (md_op_i == MD_MULT) || (md_op_i == MD_MULTU) ||
                    (md_op_i == MD_DIV)  || (md_op_i == MD_DIVU);
  assign md_sign  = (md_op_i == MD_MULT) || (md_op_i == MD_DIV);
  assign md_div   = (md_op_i == MD_DIV)  || (md_op_i == MD_DIVU);
  assign md_kill  = md_start || (md_op_i == MD_MT);

  // Any MD op (including MFHI/MFLO) waits until HI/LO are settled.
  assign in_ready_o     = !mem_stall_i && !((md_op_i != MD_NONE) && (state_q != S_IDLE));
  assign accept         = in_valid_i && in_ready_o;
  assign taken          = accept && branch_i && alu_res[0];
  assign branch_taken_o = taken;

  assign result = (md_op_i == MD_MFHI) ? hi_q :
                  (md_op_i == MD_MFLO) ? lo_q : alu_res;

  assign a_mag = (md_sign && rs_fwd[WIDTH-1]) ? -rs_fwd : rs_fwd;
  assign b_mag = (md_sign && rt_fwd[WIDTH-1]) ? -rt_fwd : rt_fwd;

  // Next EX/MEM contents for an accepted instruction, or a bubble.
  always_comb begin
    out_d = '0;
    if (accept) begin
      out_d.valid      = 1'b1;
      out_d.reg_write  = reg_write_i && !taken && !md_kill;
      out_d.mem_read   = mem_read_i && !taken;
      out_d.mem_write  = mem_write_i && !taken;
      out_d.mem_to_reg = mem_to_reg_i;
      out_d.wr_reg     = wr_reg_i;
      out_d.result     = result;
      out_d.store_data = rt_fwd;
      out_d.pc_plus4   = pc_plus4_i;
    end
  end

  // Iteration datapath: BPI shift-add or restoring-divide steps per cycle,
  // masked once all WIDTH bits have been consumed.
  always_comb begin
    step_hi = work_hi_q;
    step_lo = work_lo_q;
    sum     = '0;
    rem     = '0;
    ge      = 1'b0;
    for (int k = 0; k < BPI; k++) begin
      if (int'(bits_q) + k < WIDTH) begin
        if (is_div_q) begin
          rem     = {step_hi, step_lo[WIDTH-1]};
          ge      = (rem >= {1'b0, opnd_q});
          step_hi = ge ? (rem[WIDTH-1:0] - opnd_q) : rem[WIDTH-1:0];
          step_lo = {step_lo[WIDTH-2:0], ge};
        end else begin
          sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
          step_hi = sum[WIDTH:1];
          step_lo = {sum[0], step_lo[WIDTH-1:1]};
        end
      end
    end
  end

  // Sign fix-up applied in FIX; divide by zero bypasses the magnitude result.
  always_comb begin
    prod_s = neg_q ? -{work_hi_q, work_lo_q} : {work_hi_q, work_lo_q};
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        fix_lo = '1;
        fix_hi = dvd_raw_q;
      end else begin
        fix_lo = neg_q  ? -work_lo_q : work_lo_q;
        fix_hi = rneg_q ? -work_hi_q : work_hi_q;
      end
    end
  end

  // MDU FSM with HI/LO; MTHI/MTLO land here too since they need IDLE anyway.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      dvd_raw_q <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      bits_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && md_start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bits_q    <= '0;
            is_div_q  <= md_div;
            work_hi_q <= '0;
            work_lo_q <= md_div ? a_mag : b_mag;
            opnd_q    <= md_div ? b_mag : a_mag;
            dvd_raw_q <= rs_fwd;
            dz_q      <= (rt_fwd == '0);
            neg_q     <= md_sign && (rs_fwd[WIDTH-1] ^ rt_fwd[WIDTH-1]);
            rneg_q    <= md_sign && rs_fwd[WIDTH-1];
          end else if (accept && md_op_i == MD_MT) begin
            if (imm_i[0]) lo_q <= rs_fwd;
            else          hi_q <= rs_fwd;
          end
        end
        S_RUN: begin
          work_hi_q <= step_hi;
          work_lo_q <= step_lo;
          cnt_q     <= cnt_q + 1'b1;
          bits_q    <= bits_q + BITS_W'(BPI);
          if (cnt_q == CNT_W'(MDU_CYCLES - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // EX/MEM register: recovery > backup > stall > accept > bubble.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      out_q <= '0;
      bk_q  <= '0;
    end else if (irq_recovery_i) begin
      out_q <= bk_q;
    end else if (irq_backup_i) begin
      bk_q  <= out_q;
      out_q <= '0;
    end else if (!mem_stall_i) begin
      out_q <= out_d;
    end
  end

  assign out_valid_o      = out_q.valid;
  assign out_reg_write_o  = out_q.reg_write;
  assign out_mem_read_o   = out_q.mem_read;
  assign out_mem_write_o  = out_q.mem_write;
  assign out_mem_to_reg_o = out_q.mem_to_reg;
  assign out_wr_reg_o     = out_q.wr_reg;
  assign out_result_o     = out_q.result;
  assign out_store_data_o = out_q.store_data;
  assign out_pc_plus4_o   = out_q.pc_plus4;
  assign mdu_busy_o       = busy_q;

endmodule
`default_nettype wire
